// File: rtl/uart_core_if.sv
// uart_core_if: bus-side transmit/receive handshake bundle for uart_core
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 loopback;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output loopback, tx_start, tx_data, rx_ready,
        input  tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  loopback, tx_start, tx_data, rx_ready,
        output tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: parametrised UART transceiver with loopback, error flags and ready/valid receive
module uart_core #(
    parameter int TICKS_PER_BIT = 87,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_core_if.slave bus,
    output logic       tx,
    input  logic       rx
);
    localparam int CW = $clog2(TICKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST  = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF  = CW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] SLAST = IW'(STOP_BITS - 1);
    localparam logic PEN = PARITY_EN != 0;
    localparam logic POD = PARITY_ODD != 0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [IW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_par, tx_par_n, tx_q, tx_bit, tx_end;

    assign tx_end      = tx_cnt == LAST;
    assign bus.tx_busy = tx_state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx_q     <= tx_bit;
        end
    end

    always_comb begin
        tx_next  = tx_state;
        tx_cnt_n = (tx_state == IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
        tx_idx_n = tx_idx;
        tx_sh_n  = tx_sh;
        tx_par_n = tx_par;
        case (tx_state)
            IDLE: if (bus.tx_start) begin
                tx_next  = START;
                tx_sh_n  = bus.tx_data;
                tx_par_n = ^bus.tx_data ^ POD;
            end
            START: if (tx_end) begin
                tx_next  = DATA;
                tx_idx_n = '0;
            end
            DATA: if (tx_end) begin
                tx_sh_n  = tx_sh >> 1;
                tx_idx_n = tx_idx == DLAST ? '0 : tx_idx + 1'b1;
                if (tx_idx == DLAST) tx_next = PEN ? PARITY : STOP;
            end
            PARITY: if (tx_end) tx_next = STOP;
            STOP: if (tx_end) begin
                tx_idx_n = tx_idx + 1'b1;
                if (tx_idx == SLAST) tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
        // the pin is registered from the next state so it never glitches
        tx_bit = tx_next == START  ? 1'b0 :
                 tx_next == DATA   ? tx_sh_n[0] :
                 tx_next == PARITY ? tx_par_n : 1'b1;
    end

    logic       rx_int, rx_s;
    logic [1:0] sync;

    assign rx_int = bus.loopback ? tx_q : rx;
    assign tx     = bus.loopback | tx_q;
    assign rx_s   = sync[1];

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx_int};
    end

    state_t               rx_state, rx_next;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [IW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_acc, rx_acc_n, rx_pe, rx_pe_n, rx_fe, rx_fe_n;
    logic                 rx_tick, done, hs;

    // the start bit is sampled at its midpoint, every later bit a full period on
    assign rx_tick = rx_cnt == (rx_state == START ? HALF : LAST);
    assign hs      = bus.rx_valid & bus.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_acc   <= 1'b0;
            rx_pe    <= 1'b0;
            rx_fe    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rx_acc   <= rx_acc_n;
            rx_pe    <= rx_pe_n;
            rx_fe    <= rx_fe_n;
        end
    end

    always_comb begin
        rx_next  = rx_state;
        rx_cnt_n = rx_tick ? '0 : rx_cnt + 1'b1;
        rx_idx_n = rx_idx;
        rx_sh_n  = rx_sh;
        rx_acc_n = rx_acc;
        rx_pe_n  = rx_pe;
        rx_fe_n  = rx_fe;
        done     = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) rx_next = START;
            end
            START: if (rx_tick) begin
                rx_next  = rx_s ? IDLE : DATA;
                rx_idx_n = '0;
                rx_acc_n = POD;
                rx_pe_n  = 1'b0;
                rx_fe_n  = 1'b0;
            end
            DATA: if (rx_tick) begin
                rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_acc_n = rx_acc ^ rx_s;
                rx_idx_n = rx_idx == DLAST ? '0 : rx_idx + 1'b1;
                if (rx_idx == DLAST) rx_next = PEN ? PARITY : STOP;
            end
            PARITY: if (rx_tick) begin
                rx_pe_n = rx_acc ^ rx_s;
                rx_next = STOP;
            end
            STOP: if (rx_tick) begin
                rx_fe_n  = rx_fe | !rx_s;
                rx_idx_n = rx_idx + 1'b1;
                if (rx_idx == SLAST) begin
                    done    = 1'b1;
                    rx_next = IDLE;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else if (done && (!bus.rx_valid || bus.rx_ready)) begin
            bus.rx_data       <= rx_sh;
            bus.rx_valid      <= 1'b1;
            bus.rx_parity_err <= rx_pe;
            bus.rx_frame_err  <= rx_fe_n;
            bus.rx_overrun    <= bus.rx_overrun & !hs;
        end else if (done) begin
            bus.rx_overrun    <= 1'b1;
        end else if (hs) begin
            bus.rx_valid      <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised UART transceiver; successor to the fixed 8N1 loopback tx/rx pairing.
- Configurable data width, parity and stop bits.
- Independent external tx/rx pins, runtime internal loopback, ready/valid receive handshake.
- Per-frame error flags: parity, framing, overrun.
- Sits between a bus-side register block and the chip pads.

Parameters:
TICKS_PER_BIT, 87, clk cycles per baud period (clk_freq/baud); must be >= 4
DATA_BITS, 8, payload bits per frame, legal 5..9, sent LSB first
PARITY_EN, 0, 1 = parity bit inserted after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
loopback  in  1  1 = rx path fed from internal tx, tx pin held 1
tx_start  in  1  start request; accepted only when tx_busy=0
tx_data  in  DATA_BITS  payload captured on accept
tx_busy  out  1  high while a frame is being shifted
tx  out  1  serial output pin, idle high
rx  in  1  serial input pin, asynchronous
rx_data  out  DATA_BITS  received payload
rx_valid  out  1  rx_data holds an unconsumed frame
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
rx_parity_err  out  1  parity mismatch on held frame
rx_frame_err  out  1  any stop bit sampled 0 on held frame
rx_overrun  out  1  sticky: at least one frame lost since last handshake

Behaviour:
- Reset (also mid-frame): tx=1, tx_busy=0, rx_valid=0, rx_data=0, all error flags 0. Both FSMs go to IDLE. Synchroniser flops are set to 1.
- Frame length F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- TX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - tx_start=1 with tx_busy=0 in cycle N captures tx_data. tx goes 0 and tx_busy goes 1 from cycle N+1.
  - Each bit is held exactly TICKS_PER_BIT cycles. tx_busy falls after F*TICKS_PER_BIT cycles; tx_start can be accepted that same cycle.
  - tx_start while busy is ignored; it is not queued.
  - Parity bit = XOR of data bits, XOR PARITY_ODD.
- Loopback mux is combinational:
  - rx_int = loopback ? tx_int : rx.
  - Pin tx = loopback ? 1 : tx_int.
  - Toggling loopback mid-frame corrupts only that frame. Recovery is via framing error and return to IDLE; no lockup.
- RX input: 2-flop synchroniser on rx_int, reset value 1.
- RX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: synchronised line 0 -> START, counter cleared.
  - START: wait TICKS_PER_BIT/2 (integer division) cycles, then sample. Sample 0 -> DATA; sample 1 -> IDLE (glitch rejected, nothing reported).
  - All further samples are taken every TICKS_PER_BIT cycles from the mid-start point.
  - Data bits shift in LSB first. Parity is checked against the same rule as TX.
  - Every stop bit is sampled; any 0 sets frame error. With STOP_BITS=2 both are checked.
  - On the last stop sample the frame completes and the FSM returns to IDLE immediately, so a start edge in the second half of the stop bit is accepted.
- Completion cycle:
  - If rx_valid=0, or rx_valid & rx_ready: rx_data, rx_parity_err, rx_frame_err load from the new frame, rx_valid=1 next cycle. rx_overrun is cleared if a handshake occurred, else kept.
  - If rx_valid=1 & rx_ready=0: new frame discarded, held data/flags unchanged, rx_overrun set to 1.
- Handshake with no completion: rx_valid, rx_parity_err, rx_frame_err and rx_overrun all clear next cycle.
- Frames with parity or framing errors are still delivered, with their flags set.
- Latency: rx_valid rises 1 cycle after the final stop-bit sample. From TX start edge to rx_valid in loopback: (F-1)*TICKS_PER_BIT + TICKS_PER_BIT/2 + 3 cycles (2 synchroniser + 1 output register), fixed for a given configuration.
- Counters sized $clog2(TICKS_PER_BIT) bits, plus a bit index of $clog2(DATA_BITS+1) bits. No counter wraps inside a bit period.

Test Plan:
- TICKS_PER_BIT=4, 8N1, loopback=1: send 0xA5 -> tx pin stays 1; tx_busy high 40 cycles; rx_data=0xA5, rx_valid=1, all error flags 0.
- 8E1 on rx pin: drive 0x3C with parity 0 -> no errors. Drive 0x3C with parity 1 -> rx_data=0x3C, rx_parity_err=1.
- 8N2: drive 0x55 with second stop bit 0 -> rx_frame_err=1, rx_data=0x55. The next frame, 0x0F, is valid once consumed and shows no error.
- Overrun, rx_ready=0: two back-to-back loopback frames 0x11, 0x22 -> rx_data=0x11, rx_overrun=1. Pulse rx_ready -> all outputs clear. Repeat with rx_ready=1 at the second completion -> rx_data=0x22, rx_overrun=0.
- Glitch: rx low for TICKS_PER_BIT/2-1 cycles -> no rx_valid, FSM in IDLE. tx_start while tx_busy=1 -> frame unchanged.
- Reset asserted mid-frame on both paths -> next cycle tx=1, tx_busy=0, rx_valid=0. A fresh 0x81 frame afterwards is received correctly.
